// File: rtl/fetch_stage_pkg.sv
// rtl/fetch_stage_pkg.sv - shared pipeline encodings and helpers for the fetch stage
//
// Purpose: next-PC select encodings, branch opcodes, bubble encoding, reset PC
//          default, the IF/ID register layout and target-address helpers.
// Ports:   none (package).

package fetch_stage_pkg;

  // Next-PC select driven by the control unit for the instruction in ID.
  typedef enum logic [1:0] {
    PCSRC_SEQ    = 2'b00,
    PCSRC_BRANCH = 2'b01,
    PCSRC_JUMP   = 2'b10,
    PCSRC_JR     = 2'b11
  } pcsrc_e;

  localparam logic [5:0]  OP_BEQ           = 6'h04;
  localparam logic [5:0]  OP_BNE           = 6'h05;
  localparam logic [31:0] NOP_INST         = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] PC_STEP          = 32'd4;

  // IF/ID pipeline register contents.
  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        valid;
  } if_id_t;

  // A bubble clears every field so a squashed slot carries no stale address.
  localparam if_id_t IF_ID_BUBBLE = '{
    inst:     NOP_INST,
    pc:       32'h0000_0000,
    pc_plus4: 32'h0000_0000,
    valid:    1'b0
  };

  // pc_plus4 + (sign-extended imm16 << 2), modulo 2^32.
  function automatic logic [31:0] branch_target(input logic [31:0] pc_plus4,
                                                input logic [31:0] inst);
    logic [31:0] offset;
    offset = {{14{inst[15]}}, inst[15:0], 2'b00};
    return pc_plus4 + offset;
  endfunction

  // Region-relative jump: keep the top nibble of pc_plus4, replace the rest.
  function automatic logic [31:0] jump_target(input logic [31:0] pc_plus4,
                                              input logic [31:0] inst);
    return {pc_plus4[31:28], inst[25:0], 2'b00};
  endfunction

endpackage

// File: rtl/next_pc_sel.sv
// rtl/next_pc_sel.sv - combinational redirect decision and next-PC mux
//
// Purpose: computes branch / jump / jr targets for the instruction in ID,
//          decides whether the front end is redirected and selects the next PC.
// Ports:
//   pc              in   current PC register
//   if_id_inst      in   instruction held in IF/ID
//   if_id_pc_plus4  in   IF/ID pc + 4
//   pcsrc           in   control-unit next-PC select
//   rs_data/rt_data in   forwarded operands of the ID instruction
//   stall           in   load-use stall (PC holds, redirect ignored)
//   imem_ready      in   fetched word valid this cycle
//   redirect        out  ID instruction changes control flow this cycle
//   pc_plus4        out  pc + 4 (wraps modulo 2^32)
//   next_pc         out  value the PC register loads when not in reset

module next_pc_sel
  import fetch_stage_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] if_id_inst,
  input  logic [31:0] if_id_pc_plus4,
  input  logic [1:0]  pcsrc,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        stall,
  input  logic        imem_ready,
  output logic        redirect,
  output logic [31:0] pc_plus4,
  output logic [31:0] next_pc
);

  pcsrc_e      sel;
  logic [5:0]  opcode;
  logic        operands_equal;
  logic        branch_taken;
  logic [31:0] target;

  assign sel            = pcsrc_e'(pcsrc);
  assign opcode         = if_id_inst[31:26];
  assign operands_equal = (rs_data == rt_data);
  assign pc_plus4       = pc + PC_STEP;

  always_comb begin
    branch_taken = 1'b0;
    if (opcode == OP_BEQ) begin
      branch_taken = operands_equal;
    end else if (opcode == OP_BNE) begin
      branch_taken = !operands_equal;
    end
  end

  always_comb begin
    redirect = 1'b0;
    target   = pc_plus4;
    unique case (sel)
      PCSRC_SEQ: begin
        redirect = 1'b0;
        target   = pc_plus4;
      end
      PCSRC_BRANCH: begin
        redirect = branch_taken;
        target   = branch_target(if_id_pc_plus4, if_id_inst);
      end
      PCSRC_JUMP: begin
        redirect = 1'b1;
        target   = jump_target(if_id_pc_plus4, if_id_inst);
      end
      PCSRC_JR: begin
        // Loaded as given; alignment is the software's problem.
        redirect = 1'b1;
        target   = rs_data;
      end
      default: begin
        redirect = 1'b0;
        target   = pc_plus4;
      end
    endcase
  end

  // Stall wins over redirect because the ID operands are not final yet;
  // a redirect still lands even when memory has nothing for us this cycle.
  always_comb begin
    next_pc = pc;
    if (stall) begin
      next_pc = pc;
    end else if (redirect) begin
      next_pc = target;
    end else if (!imem_ready) begin
      next_pc = pc;
    end else begin
      next_pc = pc_plus4;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - PC register and IF/ID pipeline register of the fetch stage
//
// Purpose: fetches one instruction per cycle from a same-cycle instruction
//          memory, handles stall / redirect / memory-wait and presents the
//          fetched word to ID one cycle later.
// Ports:
//   clk, rst        in   clock, synchronous active-high reset
//   stall           in   hold PC and IF/ID
//   pcsrc           in   next-PC select for the ID instruction
//   rs_data/rt_data in   forwarded operands of the ID instruction
//   imem_addr       out  instruction-memory address (= PC)
//   imem_inst       in   instruction word at imem_addr
//   imem_ready      in   imem_inst valid this cycle
//   if_id_inst      out  instruction to ID (0 = bubble)
//   if_id_pc        out  address of if_id_inst
//   if_id_pc_plus4  out  if_id_pc + 4
//   if_id_valid     out  if_id_inst is a real fetched instruction

module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic [1:0]  pcsrc,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_inst,
  input  logic        imem_ready,
  output logic [31:0] if_id_inst,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc_plus4,
  output logic        if_id_valid
);

  logic [31:0] pc_q;
  if_id_t      if_id_q;
  logic        redirect;
  logic [31:0] pc_plus4;
  logic [31:0] next_pc;

  next_pc_sel u_next_pc_sel (
    .pc             (pc_q),
    .if_id_inst     (if_id_q.inst),
    .if_id_pc_plus4 (if_id_q.pc_plus4),
    .pcsrc          (pcsrc),
    .rs_data        (rs_data),
    .rt_data        (rt_data),
    .stall          (stall),
    .imem_ready     (imem_ready),
    .redirect       (redirect),
    .pc_plus4       (pc_plus4),
    .next_pc        (next_pc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      if_id_q <= IF_ID_BUBBLE;
    end else begin
      pc_q <= next_pc;
      if (!stall) begin
        // No delay slot: the word fetched alongside a redirect is squashed.
        if (redirect || !imem_ready) begin
          if_id_q <= IF_ID_BUBBLE;
        end else begin
          if_id_q <= '{inst: imem_inst, pc: pc_q, pc_plus4: pc_plus4, valid: 1'b1};
        end
      end
    end
  end

  assign imem_addr      = pc_q;
  assign if_id_inst     = if_id_q.inst;
  assign if_id_pc       = if_id_q.pc;
  assign if_id_pc_plus4 = if_id_q.pc_plus4;
  assign if_id_valid    = if_id_q.valid;

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, address of the first instruction fetched after reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 stall  input  1  load-use stall from the control unit; holds PC and IF/ID.
REQ-005 pcsrc  input  2  control-unit next-PC select for the ID instruction: 00 seq, 01 branch, 10 j/jal, 11 jr/jalr.
REQ-006 rs_data  input  32  forwarded rs operand of the ID instruction.
REQ-007 rt_data  input  32  forwarded rt operand of the ID instruction.
REQ-008 imem_addr  output  32  instruction-memory address, equal to the PC register.
REQ-009 imem_inst  input  32  instruction word returned for imem_addr, same cycle.
REQ-010 imem_ready  input  1  imem_inst valid this cycle.
REQ-011 if_id_inst  output  32  registered instruction presented to ID; 32'h0 is a bubble.
REQ-012 if_id_pc  output  32  registered address of if_id_inst.
REQ-013 if_id_pc_plus4  output  32  registered if_id_pc + 4.
REQ-014 if_id_valid  output  1  high when if_id_inst is a real fetched instruction.

Function
REQ-015 PC register advances one fetch per cycle; IF/ID register captures {imem_inst, PC, PC+4, 1} when it loads a fetched instruction.
REQ-016 Branch target = if_id_pc_plus4 + (sign-extended if_id_inst[15:0] << 2), 32-bit modulo arithmetic.
REQ-017 Jump target = {if_id_pc_plus4[31:28], if_id_inst[25:0], 2'b00}; jr target = rs_data.
REQ-018 redirect asserted when pcsrc=10, pcsrc=11, pcsrc=01 with opcode 6'h04 and rs_data==rt_data, or pcsrc=01 with opcode 6'h05 and rs_data!=rt_data.
REQ-019 Priority per cycle: rst > stall > redirect > imem_ready low > sequential.
REQ-020 stall high: PC and all IF/ID outputs hold; redirect is ignored (operands not yet valid).
REQ-021 redirect (no stall): PC <= selected target; IF/ID <= bubble (inst 0, valid 0, pc fields 0); no delay slot.
REQ-022 imem_ready low (no stall, no redirect): PC holds; IF/ID <= bubble.
REQ-023 Sequential (no stall, no redirect, imem_ready high): PC <= PC+4; IF/ID loads fetched instruction.
REQ-024 PC+4 wraps from 32'hFFFF_FFFC to 32'h0000_0000 without error.
REQ-025 Redirect while imem_ready is low still updates PC to the target.
REQ-026 Targets are not checked for alignment; jr to an unaligned address is loaded as given.
REQ-027 Latency: instruction at PC in cycle n appears on if_id_* in cycle n+1 when loaded.

Reset
REQ-028 rst high at a clock edge: PC <= RESET_PC; if_id_inst <= 0, if_id_pc <= 0, if_id_pc_plus4 <= 0, if_id_valid <= 0.
REQ-029 rst overrides stall, redirect and imem_ready in the same cycle, including mid-stall or mid-redirect.
REQ-030 First fetch from RESET_PC occurs in the first cycle with rst low.

Structure
REQ-031 Shared pipeline package holds PCSRC_SEQ/BRANCH/JUMP/JR encodings, OP_BEQ=6'h04, OP_BNE=6'h05, NOP_INST=32'h0, RESET_PC default.
REQ-032 One sub-module, next_pc_sel: combinational target computation, taken decision and next-PC mux; PC and IF/ID registers stay in fetch_stage.

Verification
REQ-033 Reset then 3 cycles imem_ready=1, pcsrc=00 -> imem_addr 0,4,8; if_id_pc 0,4 with valid=1.
REQ-034 ID holds beq, imm=16'h0003, if_id_pc=32'h10, rs_data=rt_data=5, pcsrc=01 -> next PC 32'h20, if_id_inst=0, valid=0; same with rt_data=6 -> PC+4 sequential.
REQ-035 stall=1 for 2 cycles with pcsrc=11, rs_data=32'h400 -> PC and IF/ID unchanged; stall drops -> PC=32'h400, bubble in IF/ID.
REQ-036 imem_ready=0 for 1 cycle at PC=32'h8 -> PC stays 32'h8, IF/ID bubble; next cycle loads instruction at 32'h8.
REQ-037 PC=32'hFFFF_FFFC sequential -> PC=32'h0, if_id_pc_plus4=32'h0.
REQ-038 rst asserted during stall=1 with pcsrc=10 -> PC=RESET_PC, IF/ID cleared next edge.
